// File: rtl/mem_pkg.sv
// Shared definitions for the handshake MEM stage: access encodings, FSM states,
// write-back source select and the alignment/legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC4  = 2'd1,
    WB_LOAD = 2'd2,
    WB_ZERO = 2'd3
  } wb_sel_t;

  // Doubleword and LWU accesses cannot be served by a 32-bit bus, so they fault too.
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [2:0] off,
                                      input int unsigned data_width);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off[1:0] != 2'b00);
      F3_WU:       bad = (data_width == 32'd32) || (off[1:0] != 2'b00);
      F3_D:        bad = (data_width == 32'd32) || (off != 3'b000);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data/enables placed on the bus lanes,
// load data shifted down to bit 0 and sign/zero extended.
module lsu_align
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NUM_COL    = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(NUM_COL)
) (
  input  logic [2:0]            funct3_i,
  input  logic [OFF_W-1:0]      off_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [NUM_COL-1:0]    be_o,
  output logic [DATA_WIDTH-1:0] ld_data_o
);

  logic [OFF_W+2:0]             bit_off_s;
  logic [7:0]                   mask_s;
  logic [6:0]                   ext_sh_s;
  logic [DATA_WIDTH-1:0]        shifted_s;
  logic [DATA_WIDTH-1:0]        left_s;
  logic signed [DATA_WIDTH-1:0] left_signed_s;

  assign bit_off_s = {off_i, 3'b000};

  // Store side: contiguous enable mask and data moved up to the addressed lane.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   mask_s = 8'h01;
      2'b01:   mask_s = 8'h03;
      2'b10:   mask_s = 8'h0F;
      default: mask_s = 8'hFF;
    endcase
    wdata_o = st_data_i << bit_off_s;
    be_o    = NUM_COL'(mask_s << off_i);
  end

  // Load side: push the field to the top, then shift back arithmetically or logically.
  always_comb begin
    shifted_s = rdata_i >> bit_off_s;
    case (funct3_i[1:0])
      2'b00:   ext_sh_s = 7'(DATA_WIDTH - 8);
      2'b01:   ext_sh_s = 7'(DATA_WIDTH - 16);
      2'b10:   ext_sh_s = 7'(DATA_WIDTH - 32);
      default: ext_sh_s = 7'd0;
    endcase
    left_s        = shifted_s << ext_sh_s;
    left_signed_s = $signed(left_s) >>> ext_sh_s;
    if (!funct3_i[2]) begin
      ld_data_o = left_signed_s;
    end else begin
      ld_data_o = left_s >> ext_sh_s;
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipelined MEM stage driving a valid/ready request, valid response memory bus;
// holds the pipeline while a transaction is outstanding and fills MEM/WB.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  localparam int NUM_COL    = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(NUM_COL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_EXMEM,
  input  logic [ADDR_WIDTH-1:0] ALU_out_EXMEM,
  input  logic [2:0]            funct3_EXMEM,
  input  logic                  mem_rd_en_EXMEM,
  input  logic                  mem_wr_en_EXMEM,
  input  logic [DATA_WIDTH-1:0] rs2_data_EXMEM,
  input  logic                  reg_wr_en_EXMEM,
  input  logic [1:0]            reg_wr_ctrl_EXMEM,
  input  logic [4:0]            rd_EXMEM,
  input  logic [ADDR_WIDTH-1:0] pc_4_EXMEM,
  output logic                  stall_MEM,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  output logic [NUM_COL-1:0]    dmem_req_be,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata,
  output logic                  valid_MEMWB,
  output logic [DATA_WIDTH-1:0] wb_data_MEMWB,
  output logic [4:0]            rd_MEMWB,
  output logic                  reg_wr_en_MEMWB,
  output logic                  misalign_MEMWB,
  output logic [ADDR_WIDTH-1:0] fault_addr_MEMWB
);

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]            rd_q, rd_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic                  misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;

  logic                  mem_op_s;
  logic                  is_load_s;
  logic                  mis_s;
  logic                  go_s;
  logic                  req_valid_s;
  logic                  stall_s;
  wb_sel_t               wb_sel_s;
  logic [DATA_WIDTH-1:0] wb_src_s;
  logic [DATA_WIDTH-1:0] ld_data_s;

  assign mem_op_s  = valid_EXMEM & (mem_rd_en_EXMEM | mem_wr_en_EXMEM);
  assign is_load_s = mem_rd_en_EXMEM;
  // Unsigned store sizes have no meaning and are flagged alongside misalignment.
  assign mis_s     = mem_op_s & (misaligned(funct3_EXMEM, ALU_out_EXMEM[2:0], DATA_WIDTH)
                               | (~mem_rd_en_EXMEM & funct3_EXMEM[2]));
  assign go_s      = mem_op_s & ~mis_s;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_lsu_align (
    .funct3_i  (funct3_EXMEM),
    .off_i     (ALU_out_EXMEM[OFF_W-1:0]),
    .st_data_i (rs2_data_EXMEM),
    .rdata_i   (dmem_rsp_rdata),
    .wdata_o   (dmem_req_wdata),
    .be_o      (dmem_req_be),
    .ld_data_o (ld_data_s)
  );

  assign dmem_req_we    = ~is_load_s;
  assign dmem_req_addr  = {ALU_out_EXMEM[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  // Masked by reset so a held EX/MEM memory op cannot raise a request during reset.
  assign dmem_req_valid = req_valid_s & reset;
  assign stall_MEM      = stall_s & reset;

  // Request/response handshake FSM.
  always_comb begin
    state_d     = state_q;
    req_valid_s = 1'b0;
    stall_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          req_valid_s = 1'b1;
          if (!dmem_req_ready) begin
            stall_s = 1'b1;
          end else if (is_load_s) begin
            stall_s = 1'b1;
            state_d = WAIT_RSP;
          end else begin
            stall_s = 1'b0;
          end
        end else begin
          req_valid_s = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          state_d = IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB next value: bubble while stalled, otherwise the finished instruction.
  always_comb begin
    wb_sel_s = wb_sel_t'(reg_wr_ctrl_EXMEM);
    case (wb_sel_s)
      WB_ALU:  wb_src_s = DATA_WIDTH'(ALU_out_EXMEM);
      WB_PC4:  wb_src_s = DATA_WIDTH'(pc_4_EXMEM);
      WB_LOAD: wb_src_s = ld_data_s;
      default: wb_src_s = {DATA_WIDTH{1'b0}};
    endcase
    if (stall_s) begin
      valid_d      = 1'b0;
      wb_data_d    = {DATA_WIDTH{1'b0}};
      rd_d         = 5'd0;
      reg_wr_en_d  = 1'b0;
      misalign_d   = 1'b0;
      fault_addr_d = {ADDR_WIDTH{1'b0}};
    end else begin
      valid_d      = valid_EXMEM;
      wb_data_d    = mis_s ? {DATA_WIDTH{1'b0}} : wb_src_s;
      rd_d         = rd_EXMEM;
      reg_wr_en_d  = valid_EXMEM & reg_wr_en_EXMEM & ~mis_s;
      misalign_d   = mis_s;
      fault_addr_d = mis_s ? ALU_out_EXMEM : {ADDR_WIDTH{1'b0}};
    end
  end

  // State and MEM/WB registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      wb_data_q    <= {DATA_WIDTH{1'b0}};
      rd_q         <= 5'd0;
      reg_wr_en_q  <= 1'b0;
      misalign_q   <= 1'b0;
      fault_addr_q <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      wb_data_q    <= wb_data_d;
      rd_q         <= rd_d;
      reg_wr_en_q  <= reg_wr_en_d;
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign valid_MEMWB      = valid_q;
  assign wb_data_MEMWB    = wb_data_q;
  assign rd_MEMWB         = rd_q;
  assign reg_wr_en_MEMWB  = reg_wr_en_q;
  assign misalign_MEMWB   = misalign_q;
  assign fault_addr_MEMWB = fault_addr_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench: directed scenarios plus random traffic against a
// byte-arithmetic reference model, for 32-bit and 64-bit instances.
module tb_mem_stage_hs;

  logic        clk = 1'b0;
  logic        reset;
  int          n_chk = 0;
  int          n_fail = 0;

  // 32-bit instance signals
  logic        valid, rd_en, wr_en, rwe, ready, rsp_valid;
  logic [31:0] addr, rs2, pc4, rdata;
  logic [2:0]  f3;
  logic [1:0]  ctl;
  logic [4:0]  rd;
  logic        stall, req_valid, req_we, vld_wb, rwe_wb, mis_wb;
  logic [31:0] req_addr, req_wdata, wb_data, fault_addr;
  logic [3:0]  req_be;
  logic [4:0]  rd_wb;

  // 64-bit instance signals
  logic        w_valid, w_rd_en, w_wr_en, w_rwe, w_ready, w_rsp_valid;
  logic [31:0] w_addr, w_pc4;
  logic [63:0] w_rs2, w_rdata;
  logic [2:0]  w_f3;
  logic [1:0]  w_ctl;
  logic [4:0]  w_rd;
  logic        w_stall, w_req_valid, w_req_we, w_vld_wb, w_rwe_wb, w_mis_wb;
  logic [31:0] w_req_addr, w_fault_addr;
  logic [63:0] w_req_wdata, w_wb_data;
  logic [7:0]  w_req_be;
  logic [4:0]  w_rd_wb;

  always #5 clk = ~clk;

  mem_stage_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_EXMEM(valid), .ALU_out_EXMEM(addr),
    .funct3_EXMEM(f3), .mem_rd_en_EXMEM(rd_en), .mem_wr_en_EXMEM(wr_en),
    .rs2_data_EXMEM(rs2), .reg_wr_en_EXMEM(rwe), .reg_wr_ctrl_EXMEM(ctl),
    .rd_EXMEM(rd), .pc_4_EXMEM(pc4), .stall_MEM(stall), .dmem_req_valid(req_valid),
    .dmem_req_ready(ready), .dmem_req_we(req_we), .dmem_req_addr(req_addr),
    .dmem_req_wdata(req_wdata), .dmem_req_be(req_be), .dmem_rsp_valid(rsp_valid),
    .dmem_rsp_rdata(rdata), .valid_MEMWB(vld_wb), .wb_data_MEMWB(wb_data),
    .rd_MEMWB(rd_wb), .reg_wr_en_MEMWB(rwe_wb), .misalign_MEMWB(mis_wb),
    .fault_addr_MEMWB(fault_addr)
  );

  mem_stage_hs #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk(clk), .reset(reset), .valid_EXMEM(w_valid), .ALU_out_EXMEM(w_addr),
    .funct3_EXMEM(w_f3), .mem_rd_en_EXMEM(w_rd_en), .mem_wr_en_EXMEM(w_wr_en),
    .rs2_data_EXMEM(w_rs2), .reg_wr_en_EXMEM(w_rwe), .reg_wr_ctrl_EXMEM(w_ctl),
    .rd_EXMEM(w_rd), .pc_4_EXMEM(w_pc4), .stall_MEM(w_stall), .dmem_req_valid(w_req_valid),
    .dmem_req_ready(w_ready), .dmem_req_we(w_req_we), .dmem_req_addr(w_req_addr),
    .dmem_req_wdata(w_req_wdata), .dmem_req_be(w_req_be), .dmem_rsp_valid(w_rsp_valid),
    .dmem_rsp_rdata(w_rdata), .valid_MEMWB(w_vld_wb), .wb_data_MEMWB(w_wb_data),
    .rd_MEMWB(w_rd_wb), .reg_wr_en_MEMWB(w_rwe_wb), .misalign_MEMWB(w_mis_wb),
    .fault_addr_MEMWB(w_fault_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction through the 32-bit stage; memory delays are scheduled, not reactive.
  task automatic run_op(input logic vld, input logic ld, input logic st, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input logic [1:0] c_sel, input logic we_rd, input logic [4:0] rdi,
                        input logic [31:0] pc, input int rdly, input int lat);
    int          size, off, nbits, last;
    logic        memop, illegal, mis, aligned;
    logic [31:0] exp_wdata, raw, mask, ldv, exp_wb;
    logic [3:0]  exp_be;
    size    = 1 << fn[1:0];
    off     = int'(a[1:0]);
    memop   = vld & (ld | st);
    illegal = (fn == 3'b111) || (fn == 3'b011) || (fn == 3'b110) || (!ld && fn[2]);
    mis     = memop && (illegal || ((a & 32'(size - 1)) != 32'd0));
    aligned = memop && !mis;
    exp_wdata = wd << (8 * off);
    exp_be    = 4'(((1 << size) - 1) << off);
    nbits = 8 * size;
    raw   = rdat >> (8 * off);
    mask  = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
    ldv   = raw & mask;
    if (!fn[2] && nbits < 32 && ldv[nbits-1]) ldv = ldv | ~mask;
    case (c_sel)
      2'd0:    exp_wb = a;
      2'd1:    exp_wb = pc;
      2'd2:    exp_wb = ldv;
      default: exp_wb = 32'd0;
    endcase
    last = aligned ? (ld ? rdly + lat : rdly) : 0;
    valid = vld; rd_en = ld; wr_en = st; f3 = fn; addr = a; rs2 = wd;
    ctl = c_sel; rwe = we_rd; rd = rdi; pc4 = pc;
    for (int c = 0; c <= last; c++) begin
      ready = aligned ? (c == rdly) : 1'($urandom % 2);
      if (aligned && ld) begin
        rsp_valid = (c == rdly + lat);
        rdata     = (c == rdly + lat) ? rdat : $urandom;
      end else begin
        rsp_valid = 1'($urandom % 2);
        rdata     = $urandom;
      end
      @(negedge clk);
      check("stall", stall, c < last);
      check("req_valid", req_valid, aligned && c <= rdly);
      if (aligned && c <= rdly) begin
        check("req_addr", req_addr, a & 32'hFFFF_FFFC);
        check("req_we", req_we, !ld);
        check("req_be", req_be, exp_be);
        if (!ld) check("req_wdata", req_wdata, exp_wdata);
      end
      @(posedge clk); #1;
      if (c < last) begin
        check("bubble_valid", vld_wb, 1'b0);
        check("bubble_rwe", rwe_wb, 1'b0);
      end else begin
        check("wb_valid", vld_wb, vld);
        check("wb_misalign", mis_wb, mis);
        check("wb_fault_addr", fault_addr, mis ? a : 32'd0);
        check("wb_reg_wr_en", rwe_wb, vld && we_rd && !mis);
        if (vld) check("wb_rd", rd_wb, rdi);
        if (vld && !mis) check("wb_data", wb_data, exp_wb);
      end
    end
    rsp_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]  ld_f3 [7];
    logic [2:0]  fn;
    logic [31:0] a;
    int          kind;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b011};
    reset = 1'b0;
    {valid, rd_en, wr_en, rwe, ready, rsp_valid} = 6'b0;
    {addr, rs2, pc4, rdata, f3, ctl, rd} = '0;
    {w_valid, w_rd_en, w_wr_en, w_rwe, w_ready, w_rsp_valid} = 6'b0;
    {w_addr, w_pc4, w_rs2, w_rdata, w_f3, w_ctl, w_rd} = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_valid", vld_wb, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_req", req_valid, 1'b0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fault", fault_addr, 32'd0);
    check("rst64_valid", w_vld_wb, 1'b0);
    reset = 1'b1;

    // SW, accepted at once
    run_op(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'd0, 0, 5'd0, 32'h4, 0, 1);
    check("t1_be", req_be, 4'b1111);
    check("t1_addr", req_addr, 32'h10);
    // SB with two ready-low cycles
    run_op(1, 0, 1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 2'd0, 0, 5'd0, 32'h8, 2, 1);
    check("t2_wdata", req_wdata, 32'hA500_0000);
    check("t2_be", req_be, 4'b1000);
    // LH / LHU, response three cycles after acceptance
    run_op(1, 1, 0, 3'b001, 32'h22, 32'h0, 32'h8001_0000, 2'd2, 1, 5'd7, 32'hC, 0, 3);
    check("t3_lh", wb_data, 32'hFFFF_8001);
    run_op(1, 1, 0, 3'b101, 32'h22, 32'h0, 32'h8001_0000, 2'd2, 1, 5'd7, 32'hC, 0, 3);
    check("t3_lhu", wb_data, 32'h0000_8001);
    // misaligned LW
    run_op(1, 1, 0, 3'b010, 32'h06, 32'h0, 32'h0, 2'd2, 1, 5'd3, 32'h10, 0, 1);
    check("t4_mis", mis_wb, 1'b1);
    check("t4_fault", fault_addr, 32'h06);

    // reset while a load response is outstanding
    valid = 1; rd_en = 1; wr_en = 0; f3 = 3'b010; addr = 32'h40; ctl = 2'd2; rwe = 1; rd = 5'd9;
    ready = 1; rsp_valid = 0;
    @(negedge clk);
    check("t5_req", req_valid, 1'b1);
    @(posedge clk); #1;
    ready = 0;
    @(negedge clk);
    check("t5_wait_stall", stall, 1'b1);
    reset = 1'b0; #1;
    check("t5_rst_stall", stall, 1'b0);
    check("t5_rst_req", req_valid, 1'b0);
    check("t5_rst_valid", vld_wb, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    valid = 0; rd_en = 0; rsp_valid = 1; rdata = 32'h1234_5678;
    @(negedge clk);
    check("t5_late_stall", stall, 1'b0);
    check("t5_late_req", req_valid, 1'b0);
    @(posedge clk); #1;
    check("t5_late_valid", vld_wb, 1'b0);
    rsp_valid = 0;
    run_op(1, 0, 1, 3'b010, 32'h44, 32'h0BAD_F00D, 32'h0, 2'd0, 0, 5'd0, 32'h48, 0, 1);

    // 64-bit: LD pass-through, then misaligned SD
    w_valid = 1; w_rd_en = 1; w_f3 = 3'b011; w_addr = 32'h08; w_ctl = 2'd2; w_rwe = 1;
    w_rd = 5'd5; w_ready = 1;
    @(negedge clk);
    check("t6_req", w_req_valid, 1'b1);
    check("t6_be", w_req_be, 8'hFF);
    check("t6_stall", w_stall, 1'b1);
    @(posedge clk); #1;
    w_ready = 0; w_rsp_valid = 1; w_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check("t6_rsp_stall", w_stall, 1'b0);
    @(posedge clk); #1;
    check("t6_ld_data", w_wb_data, 64'h0123_4567_89AB_CDEF);
    check("t6_ld_valid", w_vld_wb, 1'b1);
    check("t6_ld_rwe", w_rwe_wb, 1'b1);
    w_rsp_valid = 0; w_rd_en = 0; w_wr_en = 1; w_addr = 32'h04; w_ctl = 2'd0; w_rwe = 0;
    @(negedge clk);
    check("t6_sd_req", w_req_valid, 1'b0);
    check("t6_sd_stall", w_stall, 1'b0);
    @(posedge clk); #1;
    check("t6_sd_mis", w_mis_wb, 1'b1);
    check("t6_sd_fault", w_fault_addr, 32'h04);
    check("t6_sd_rwe", w_rwe_wb, 1'b0);
    w_valid = 0; w_wr_en = 0;

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom;
      if (kind == 1) fn = ld_f3[$urandom_range(0, 6)];
      else           fn = 3'($urandom_range(0, 3));
      if ($urandom % 2 == 0) a = a & ~32'((1 << fn[1:0]) - 1);
      case (kind)
        1:       run_op(($urandom % 8) != 0, 1, 0, fn, a, $urandom, $urandom, 2'd2, 1,
                        5'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(1, 3));
        2:       run_op(($urandom % 8) != 0, 0, 1, fn, a, $urandom, $urandom, 2'd0, 0,
                        5'($urandom), $urandom, $urandom_range(0, 2), 1);
        default: run_op(($urandom % 8) != 0, 0, 0, fn, a, $urandom, $urandom,
                        2'($urandom_range(0, 1)), 1, 5'($urandom), $urandom, 0, 1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
